// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Build option: MCU_JUMP_EN adds the JUMP state and opcode 010.
package mcu_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    BRANCH,
    TRAP
`ifdef MCU_JUMP_EN
    , JUMP
`endif
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_JUMP = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_SLT   = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_OUT  = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;

endpackage

// File: rtl/mcu_out_decode.sv
// State-to-control decode; purely combinational.
// Build option: MCU_JUMP_EN adds the JUMP decode.
module mcu_out_decode
  import mcu_pkg::*;
(
  input  state_t     state,
  input  logic       memReady,
  input  logic       regDstQ,
  input  logic       sltiQ,
  input  logic       kill,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       irWrite,
  output logic       iOrD,
  output logic       memRead,
  output logic       memWrite,
  output logic       regDst,
  output logic       regWrite,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegal
);

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    irWrite     = 1'b0;
    iOrD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REG;
    aluOp       = ALU_FUNCT;
    pcSource    = PC_ALU;
    illegal     = 1'b0;
    // Reset forces every strobe and select low.
    if (!kill) begin
      unique case (state)
        FETCH: begin
          memRead = 1'b1;
          aluSrcB = SRCB_FOUR;
          aluOp   = ALU_ADD;
          irWrite = memReady;
          pcWrite = memReady;
        end
        DECODE: begin
          aluSrcB = SRCB_SHIMM;
          aluOp   = ALU_ADD;
        end
        MEM_ADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
          aluOp   = ALU_ADD;
        end
        MEM_RD: begin
          memRead = 1'b1;
          iOrD    = 1'b1;
        end
        MEM_WB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
        end
        MEM_WR: begin
          memWrite = 1'b1;
          iOrD     = 1'b1;
        end
        EXEC_R: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_REG;
          aluOp   = ALU_FUNCT;
        end
        EXEC_I: begin
          aluSrcA = 1'b1;
          aluSrcB = SRCB_IMM;
          aluOp   = sltiQ ? ALU_SLT : ALU_ADD;
        end
        ALU_WB: begin
          regWrite = 1'b1;
          regDst   = regDstQ;
        end
        BRANCH: begin
          aluSrcA     = 1'b1;
          aluSrcB     = SRCB_REG;
          aluOp       = ALU_SUB;
          pcWriteCond = 1'b1;
          pcSource    = PC_OUT;
        end
        TRAP: illegal = 1'b1;
`ifdef MCU_JUMP_EN
        JUMP: begin
          pcWrite  = 1'b1;
          pcSource = PC_JUMP;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM control: state register, sequencing, retire counter.
// Build option: MCU_JUMP_EN enables the JUMP instruction (opcode 010).
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  state_t     state;
  state_t     nextState;
  logic       regDstQ;
  logic       sltiQ;
  logic       opHiZero;
  logic [2:0] opLow;
  logic       retire;

  assign opHiZero = ((opcode >> 3) == '0);
  assign opLow    = opcode[2:0];

  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:    if (mem_ready) nextState = DECODE;
      DECODE: begin
        nextState = TRAP;
        if (opHiZero) begin
          case (opLow)
            OP_LW, OP_SW:     nextState = MEM_ADDR;
            OP_R:             nextState = EXEC_R;
            OP_ADDI, OP_SLTI: nextState = EXEC_I;
            OP_BEQ:           nextState = BRANCH;
`ifdef MCU_JUMP_EN
            OP_JUMP:          nextState = JUMP;
`endif
            default:          nextState = TRAP;
          endcase
        end
      end
      MEM_ADDR: nextState = (opLow == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) nextState = MEM_WB;
      MEM_WR:   if (mem_ready) nextState = FETCH;
      EXEC_R:   nextState = ALU_WB;
      EXEC_I:   nextState = ALU_WB;
      default:  nextState = FETCH;
    endcase
  end

  // TRAP returns to FETCH without retiring.
  always_comb begin
    retire = 1'b0;
    unique case (state)
      MEM_WB, ALU_WB, BRANCH: retire = 1'b1;
      MEM_WR:                 retire = mem_ready;
`ifdef MCU_JUMP_EN
      JUMP:                   retire = 1'b1;
`endif
      default:                retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      instr_count <= '0;
      regDstQ     <= 1'b0;
      sltiQ       <= 1'b0;
    end else begin
      state <= nextState;
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (state == DECODE) sltiQ <= (opLow == OP_SLTI);
      if (state == EXEC_R) regDstQ <= 1'b1;
      if (state == EXEC_I) regDstQ <= 1'b0;
    end
  end

  mcu_out_decode uDecode (
    .state       (state),
    .memReady    (mem_ready),
    .regDstQ     (regDstQ),
    .sltiQ       (sltiQ),
    .kill        (rst),
    .pcWrite     (pc_write),
    .pcWriteCond (pc_write_cond),
    .irWrite     (ir_write),
    .iOrD        (i_or_d),
    .memRead     (mem_read),
    .memWrite    (mem_write),
    .regDst      (reg_dst),
    .regWrite    (reg_write),
    .memToReg    (mem_to_reg),
    .aluSrcA     (alu_src_a),
    .aluSrcB     (alu_src_b),
    .aluOp       (alu_op),
    .pcSource    (pc_source),
    .illegal     (illegal)
  );

endmodule
